// File: rtl/axis_tiny_upsizer_if.sv
// Signal bundle for axis_tiny_upsizer: the narrow input stream and the
// wide output stream. The slave modport is the upsizer itself; the master
// modport is its environment (upstream source plus downstream sink).
interface axis_tiny_upsizer_if #(
    parameter int BUS_WIDTH = 2,
    parameter int RATIO     = 2
);
    logic                           s_axis_tvalid;
    logic                           s_axis_tready;
    logic [BUS_WIDTH*8-1:0]         s_axis_tdata;
    logic                           s_axis_tlast;

    logic                           m_axis_tvalid;
    logic                           m_axis_tready;
    logic [BUS_WIDTH*RATIO*8-1:0]   m_axis_tdata;
    logic [BUS_WIDTH*RATIO-1:0]     m_axis_tkeep;
    logic                           m_axis_tlast;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );
endinterface

// File: rtl/axis_tiny_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow beats into one wide beat.
// The output register doubles as the accumulation buffer, so there is no
// extra storage; a word ending early on tlast leaves with partial tkeep.
module axis_tiny_upsizer #(
    parameter int BUS_WIDTH = 2,
    parameter int RATIO     = 2
) (
    input  logic               aclk,
    input  logic               arst,
    axis_tiny_upsizer_if.slave bus
);
    localparam int DW    = BUS_WIDTH * 8;
    localparam int OW    = DW * RATIO;
    localparam int KW    = BUS_WIDTH * RATIO;
    localparam int CNT_W = ($clog2(RATIO) > 1) ? $clog2(RATIO) : 1;

    logic [CNT_W-1:0] cnt;
    logic [OW-1:0]    data_q;
    logic [KW-1:0]    keep_q;
    logic             last_q;
    logic             valid_q;

    logic [OW-1:0]    data_nxt;
    logic [KW-1:0]    keep_nxt;
    logic             accept;
    logic             drain;
    logic             complete;

    // Input may be taken whenever the output register is empty or leaving now.
    assign bus.s_axis_tready = ~arst & (~valid_q | bus.m_axis_tready);
    assign accept            = bus.s_axis_tvalid & bus.s_axis_tready;
    assign drain             = valid_q & bus.m_axis_tready;
    assign complete          = (cnt == CNT_W'(RATIO - 1)) | bus.s_axis_tlast;

    assign bus.m_axis_tvalid = valid_q;
    assign bus.m_axis_tdata  = data_q;
    assign bus.m_axis_tkeep  = keep_q;
    assign bus.m_axis_tlast  = last_q;

    // Merge the incoming beat into lane cnt; a new word starts from a clean slate.
    always_comb begin
        data_nxt = (cnt == '0) ? '0 : data_q;
        keep_nxt = (cnt == '0) ? '0 : keep_q;
        for (int i = 0; i < RATIO; i++) begin
            if (cnt == CNT_W'(i)) begin
                data_nxt[i*DW +: DW]               = bus.s_axis_tdata;
                keep_nxt[i*BUS_WIDTH +: BUS_WIDTH] = '1;
            end
        end
    end

    // Lane counter and output register: accumulate, complete, drain.
    always_ff @(posedge aclk) begin
        if (arst) begin
            cnt     <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (drain) begin
                valid_q <= 1'b0;
            end
            if (accept) begin
                data_q <= data_nxt;
                keep_q <= keep_nxt;
                if (complete) begin
                    valid_q <= 1'b1;
                    last_q  <= bus.s_axis_tlast;
                    cnt     <= '0;
                end else begin
                    cnt     <= cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_tiny_upsizer.sv
// Self-checking bench for axis_tiny_upsizer: a RATIO=2 and a RATIO=3
// instance, directed table vectors, hand-written corner sequences and a
// randomized byte-stream scoreboard.
module tb_axis_tiny_upsizer;
    logic aclk = 1'b0;
    logic arst = 1'b1;
    always #5 aclk = ~aclk;

    axis_tiny_upsizer_if #(.BUS_WIDTH(2), .RATIO(2)) bus2 ();
    axis_tiny_upsizer_if #(.BUS_WIDTH(2), .RATIO(3)) bus3 ();

    axis_tiny_upsizer #(.BUS_WIDTH(2), .RATIO(2)) u_dut2 (.aclk(aclk), .arst(arst), .bus(bus2.slave));
    axis_tiny_upsizer #(.BUS_WIDTH(2), .RATIO(3)) u_dut3 (.aclk(aclk), .arst(arst), .bus(bus3.slave));

    typedef struct {
        logic [47:0] d;
        logic [5:0]  k;
        logic        l;
    } word_t;

    typedef struct {
        logic [7:0] b;
        logic       l;
    } byte_t;

    typedef struct {
        bit          sel;
        logic [15:0] d;
        bit          l;
        bit          push;
        logic [47:0] ed;
        logic [5:0]  ek;
        bit          el;
    } vec_t;

    word_t q2[$];
    word_t q3[$];
    byte_t bq[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    rnd_mode = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input bit sel, input logic [15:0] d, input bit l, output int stalls);
        bit hs;
        bit done;
        stalls = 0;
        done   = 1'b0;
        if (sel) begin
            bus3.s_axis_tvalid = 1'b1; bus3.s_axis_tdata = d; bus3.s_axis_tlast = l;
        end else begin
            bus2.s_axis_tvalid = 1'b1; bus2.s_axis_tdata = d; bus2.s_axis_tlast = l;
        end
        for (int i = 0; i < 1000; i++) begin
            #4;
            hs = sel ? bus3.s_axis_tready : bus2.s_axis_tready;
            @(negedge aclk);
            if (hs) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        if (!done) fail_now("send_timeout");
    endtask

    task automatic idle(input bit sel);
        if (sel) bus3.s_axis_tvalid = 1'b0;
        else     bus2.s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (q2.size() == 0 && q3.size() == 0 && bq.size() == 0) begin
                empty = 1'b1;
                break;
            end
            @(negedge aclk);
        end
        if (!empty) fail_now("drain_timeout");
    endtask

    // Random sink readiness during the scoreboard phase.
    always @(negedge aclk) begin
        if (rnd_mode) bus2.m_axis_tready = ($urandom_range(0, 3) != 0);
    end

    // Output monitor for the RATIO=2 instance, sampled just before each rising edge.
    logic        prev_stall2 = 1'b0;
    logic [36:0] prev_pay2;
    always begin
        @(negedge aclk);
        #4;
        if (arst) begin
            prev_stall2 = 1'b0;
        end else begin
            if (prev_stall2) begin
                chk("hold_valid", bus2.m_axis_tvalid, 1);
                chk("hold_payload", {bus2.m_axis_tlast, bus2.m_axis_tkeep, bus2.m_axis_tdata}, prev_pay2);
            end
            if (bus2.m_axis_tvalid && bus2.m_axis_tready) begin
                if (rnd_mode) begin
                    bit   seen_gap;
                    bit   last_b;
                    byte_t e;
                    seen_gap = 1'b0;
                    last_b   = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        if (bus2.m_axis_tkeep[i]) begin
                            chk("rnd_keep_contig", seen_gap, 0);
                            if (bq.size() == 0) begin
                                fail_now("rnd_extra_byte");
                            end else begin
                                e = bq.pop_front();
                                chk("rnd_byte", bus2.m_axis_tdata[i*8 +: 8], e.b);
                                last_b = e.l;
                            end
                        end else begin
                            seen_gap = 1'b1;
                        end
                    end
                    chk("rnd_last", bus2.m_axis_tlast, last_b);
                    if (!bus2.m_axis_tlast) chk("rnd_full_word", bus2.m_axis_tkeep, 4'hF);
                end else if (q2.size() == 0) begin
                    fail_now("unexpected_word_dut2");
                end else begin
                    word_t w;
                    w = q2.pop_front();
                    chk("word_data", bus2.m_axis_tdata, w.d[31:0]);
                    chk("word_keep", bus2.m_axis_tkeep, w.k[3:0]);
                    chk("word_last", bus2.m_axis_tlast, w.l);
                end
            end
            prev_stall2 = bus2.m_axis_tvalid & ~bus2.m_axis_tready;
            prev_pay2   = {bus2.m_axis_tlast, bus2.m_axis_tkeep, bus2.m_axis_tdata};
        end
    end

    // Output monitor for the RATIO=3 instance.
    always begin
        @(negedge aclk);
        #4;
        if (!arst && bus3.m_axis_tvalid && bus3.m_axis_tready) begin
            if (q3.size() == 0) begin
                fail_now("unexpected_word_dut3");
            end else begin
                word_t w;
                w = q3.pop_front();
                chk("word3_data", bus3.m_axis_tdata, w.d);
                chk("word3_keep", bus3.m_axis_tkeep, w.k);
                chk("word3_last", bus3.m_axis_tlast, w.l);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        int   st;
        logic [15:0] rd;
        bit   rl;

        vecs[0]  = '{0, 16'h1111, 0, 0, 48'h0,            6'h00, 0};
        vecs[1]  = '{0, 16'h2222, 0, 1, 48'h22221111,     6'h0F, 0};
        vecs[2]  = '{0, 16'h3333, 0, 0, 48'h0,            6'h00, 0};
        vecs[3]  = '{0, 16'h4444, 1, 1, 48'h44443333,     6'h0F, 1};
        vecs[4]  = '{0, 16'hAAAA, 1, 1, 48'h0000AAAA,     6'h03, 1};
        vecs[5]  = '{0, 16'hBBBB, 0, 0, 48'h0,            6'h00, 0};
        vecs[6]  = '{0, 16'hCCCC, 1, 1, 48'hCCCCBBBB,     6'h0F, 1};
        vecs[7]  = '{1, 16'h0001, 0, 0, 48'h0,            6'h00, 0};
        vecs[8]  = '{1, 16'h0002, 0, 0, 48'h0,            6'h00, 0};
        vecs[9]  = '{1, 16'h0003, 0, 1, 48'h000300020001, 6'h3F, 0};
        vecs[10] = '{1, 16'h0004, 0, 0, 48'h0,            6'h00, 0};

        bus2.s_axis_tvalid = 0; bus2.s_axis_tdata = '0; bus2.s_axis_tlast = 0; bus2.m_axis_tready = 1;
        bus3.s_axis_tvalid = 0; bus3.s_axis_tdata = '0; bus3.s_axis_tlast = 0; bus3.m_axis_tready = 1;

        // Reset state
        arst = 1'b1;
        repeat (2) @(negedge aclk);
        #4;
        chk("rst_s_tready2", bus2.s_axis_tready, 0);
        chk("rst_s_tready3", bus3.s_axis_tready, 0);
        chk("rst_m_tvalid2", bus2.m_axis_tvalid, 0);
        chk("rst_m_tdata2",  bus2.m_axis_tdata, 0);
        chk("rst_m_tkeep2",  bus2.m_axis_tkeep, 0);
        chk("rst_m_tlast2",  bus2.m_axis_tlast, 0);
        chk("rst_m_tvalid3", bus3.m_axis_tvalid, 0);
        chk("rst_m_tkeep3",  bus3.m_axis_tkeep, 0);
        @(negedge aclk);
        arst = 1'b0;
        #4;
        chk("post_rst_s_tready2", bus2.s_axis_tready, 1);
        @(negedge aclk);

        // Table vectors: back-to-back packing, partial flush, RATIO=3 overlap
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].push) begin
                if (vecs[i].sel) q3.push_back('{vecs[i].ed, vecs[i].ek, vecs[i].el});
                else             q2.push_back('{vecs[i].ed, vecs[i].ek, vecs[i].el});
            end
            send(vecs[i].sel, vecs[i].d, vecs[i].l, st);
            chk($sformatf("no_stall_%0d", i), st, 0);
            if (vecs[i].push) begin
                chk($sformatf("latency_%0d", i), vecs[i].sel ? bus3.m_axis_tvalid : bus2.m_axis_tvalid, 1);
            end
            if (i == 6) idle(0);
        end
        q3.push_back('{48'h000600050004, 6'h3F, 1'b1});
        send(1, 16'h0005, 0, st);
        chk("no_stall_5", st, 0);
        send(1, 16'h0006, 1, st);
        chk("no_stall_6", st, 0);
        idle(1);
        wait_drain();

        // Backpressure: word held for 5 cycles, pending beat taken on release
        bus2.m_axis_tready = 1'b0;
        q2.push_back('{48'h56781234, 6'h0F, 1'b0});
        send(0, 16'h1234, 0, st);
        send(0, 16'h5678, 0, st);
        bus2.s_axis_tvalid = 1'b1; bus2.s_axis_tdata = 16'h9ABC; bus2.s_axis_tlast = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #4;
            chk("bp_s_tready_low", bus2.s_axis_tready, 0);
            chk("bp_m_tvalid", bus2.m_axis_tvalid, 1);
            chk("bp_m_tdata", bus2.m_axis_tdata, 32'h56781234);
            @(negedge aclk);
        end
        bus2.m_axis_tready = 1'b1;
        #4;
        chk("bp_release_s_tready", bus2.s_axis_tready, 1);
        @(negedge aclk);
        q2.push_back('{48'hDEF09ABC, 6'h0F, 1'b1});
        send(0, 16'hDEF0, 1, st);
        chk("bp_resume_no_stall", st, 0);
        idle(0);
        wait_drain();

        // Reset mid-packet discards the partial word
        send(0, 16'h5555, 0, st);
        idle(0);
        arst = 1'b1;
        #4;
        chk("midrst_s_tready", bus2.s_axis_tready, 0);
        @(negedge aclk);
        arst = 1'b0;
        #4;
        chk("midrst_m_tvalid", bus2.m_axis_tvalid, 0);
        chk("midrst_m_tkeep", bus2.m_axis_tkeep, 0);
        @(negedge aclk);
        q2.push_back('{48'h77776666, 6'h0F, 1'b1});
        send(0, 16'h6666, 0, st);
        send(0, 16'h7777, 1, st);
        idle(0);
        wait_drain();

        // Random valid/ready with random tlast, checked as a byte stream
        rnd_mode = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            if (gaps != 0) begin
                idle(0);
                repeat (gaps) @(negedge aclk);
            end
            rd = 16'($urandom);
            rl = (n == 999) || ($urandom_range(0, 4) == 0);
            bq.push_back('{rd[7:0], 1'b0});
            bq.push_back('{rd[15:8], rl});
            send(0, rd, rl, st);
        end
        idle(0);
        wait_drain();
        rnd_mode = 1'b0;
        @(negedge aclk);
        bus2.m_axis_tready = 1'b1;
        repeat (3) @(negedge aclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
